// File: rtl/tt_um_seg7_stream_checker_if.sv
// Tiny Tapeout tile pin bundle for the 7-segment stream checker.
//   ui_in   : [6:0] segment pattern (a=bit0 .. g=bit6), [7] frame marker
//   uio_in  : [0] err_clear, [7:1] ignored
//   uo_out  : [3:0] nibble, [4] valid, [5] locked, [6] mismatch, [7] frame
//   uio_out : [7:1] error count, [0] zero
//   uio_oe  : bidirectional output enables
// master drives the tile inputs, slave is the checker tile.
interface tt_um_seg7_stream_checker_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_seg7_stream_checker.sv
// 7-segment hex stream checker. Synchronizes the incoming segment/marker
// stream, decodes each pattern to a nibble, locks on the F+marker digit and
// then checks that digits arrive as 0..F in order. Mismatches are pulsed
// and counted in a saturating 7-bit counter; three misses in a row drop lock.
// Ports:
//   clk   : system clock, one digit sampled per rising edge
//   rst_n : asynchronous active-low reset
//   ena   : tile enable, all state holds while low
//   bus   : tile pins (see tt_um_seg7_stream_checker_if)
module tt_um_seg7_stream_checker (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    tt_um_seg7_stream_checker_if.slave        bus
);

    localparam int MISS_LIMIT = 3;
    localparam int ERR_W      = 7;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic {HUNT, LOCKED} state_t;

    // two-flop synchronizers
    logic [7:0] ui_s1, ui_s2;
    logic       clr_s1, clr_s2;

    // decoded sample from the synchronized stream
    logic [3:0] dec_nib;
    logic       dec_valid;
    logic       marker;
    logic       frame_hit;
    logic       match;

    // checker state and registered outputs
    state_t           state;
    logic [3:0]       expected;
    logic [1:0]       miss;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       nibble_q;
    logic             valid_q;
    logic             mismatch_q;
    logic             frame_q;

    logic unused_uio_in;
    assign unused_uio_in = &{1'b0, bus.uio_in[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_s1  <= '0;
            ui_s2  <= '0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
        end else if (ena) begin
            ui_s1  <= bus.ui_in;
            ui_s2  <= ui_s1;
            clr_s1 <= bus.uio_in[0];
            clr_s2 <= clr_s1;
        end
    end

    always_comb begin
        dec_valid = 1'b1;
        dec_nib   = 4'h0;
        case (ui_s2[6:0])
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: begin
                dec_valid = 1'b0;
                dec_nib   = 4'h0;
            end
        endcase
    end

    assign marker    = ui_s2[7];
    assign frame_hit = marker & dec_valid & (dec_nib == 4'hF);
    // the marker must be present on F and absent everywhere else
    assign match     = dec_valid & (dec_nib == expected) & (marker == (expected == 4'hF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            expected   <= 4'h0;
            miss       <= 2'd0;
            err_count  <= '0;
            nibble_q   <= 4'h0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            frame_q    <= 1'b0;
        end else if (ena) begin
            nibble_q   <= dec_nib;
            valid_q    <= dec_valid;
            frame_q    <= frame_hit;
            mismatch_q <= 1'b0;
            case (state)
                HUNT: begin
                    if (frame_hit) begin
                        state    <= LOCKED;
                        expected <= 4'h0;
                        miss     <= 2'd0;
                    end
                end
                LOCKED: begin
                    // flywheel: expected advances whether or not the digit matched
                    expected <= expected + 4'd1;
                    if (match) begin
                        miss <= 2'd0;
                    end else begin
                        mismatch_q <= 1'b1;
                        if (miss == 2'(MISS_LIMIT - 1)) begin
                            state <= HUNT;
                            miss  <= 2'd0;
                        end else begin
                            miss <= miss + 2'd1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
            // clear has priority over a coincident mismatch
            if (clr_s2)
                err_count <= '0;
            else if (state == LOCKED && !match && err_count != ERR_MAX)
                err_count <= err_count + 1'b1;
        end
    end

    assign bus.uo_out  = {frame_q, mismatch_q, (state == LOCKED), valid_q, nibble_q};
    assign bus.uio_out = {err_count, 1'b0};
    assign bus.uio_oe  = 8'hFE;

endmodule
